// File: rtl/tile_bram_loader.sv
// Purpose: sweeps a TILE_DIM x TILE_DIM array of tile BRAMs over port A, loading them from a stream or dumping them to one.
// Latency: a load write issues one cycle after its input handshake; a dump word takes 3 cycles (address, read wait, output).
// Backpressure: in_ready only in WR; RD_OUT holds out_data until out_ready. Optional checksum: define TILE_LOADER_CHECKSUM_EN.
module tile_bram_loader #(
    parameter int TILE_DIM = 2,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    input  logic              start_in,
    output logic              start_out,
    output logic              busy,
    output logic              done,
    output logic              external,
    output logic [7:0]        BRAM_i,
    output logic [7:0]        BRAM_j,
    output logic              WEA,
    output logic [ADDR_W-1:0] ADDRA,
    output logic [15:0]       DIA,
    input  logic [15:0]       DOA,
    output logic [15:0]       checksum
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0] DIM_MAX = 8'(TILE_DIM - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_m1_q, len_m1_d;   // words per BRAM minus one; cmd_len=0 wraps to all ones
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [15:0]       dia_q, dia_d;
    logic [7:0]        bram_i_q, bram_i_d;
    logic [7:0]        bram_j_q, bram_j_d;
    logic [15:0]       out_data_q, out_data_d;

    logic              cmd_hs, in_hs, out_hs;
    logic              addr_last, j_last, i_last, last_word;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        i_nx, j_nx;

    assign cmd_hs    = cmd_valid && (state_q == S_IDLE);
    assign in_hs     = in_valid  && (state_q == S_WR);
    assign out_hs    = out_ready && (state_q == S_RD_OUT);

    assign addr_last = (addr_q == len_m1_q);
    assign j_last    = (j_q == DIM_MAX);
    assign i_last    = (i_q == DIM_MAX);
    assign last_word = addr_last && j_last && i_last;

    // Sweep counters: addr fastest, then j, then i; everything wraps to zero after the final word.
    always_comb begin
        addr_nx = addr_last ? '0 : addr_q + ADDR_W'(1);
        j_nx    = j_q;
        i_nx    = i_q;
        if (addr_last) begin
            j_nx = j_last ? 8'd0 : j_q + 8'd1;
            if (j_last) begin
                i_nx = i_last ? 8'd0 : i_q + 8'd1;
            end
        end
    end

    // Next-state logic of the command FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_valid) state_d = cmd_write ? S_WR : S_RD_ADDR;
            S_WR:      if (in_valid && last_word) state_d = S_DONE;
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_OUT;
            S_RD_OUT:  if (out_ready) state_d = last_word ? S_DONE : S_RD_ADDR;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values: port-A outputs are registered, so a write lands the cycle after its handshake.
    always_comb begin
        len_m1_d   = len_m1_q;
        addr_d     = addr_q;
        i_d        = i_q;
        j_d        = j_q;
        wea_d      = 1'b0;
        addra_d    = addra_q;
        dia_d      = dia_q;
        bram_i_d   = bram_i_q;
        bram_j_d   = bram_j_q;
        out_data_d = out_data_q;
        if (cmd_hs) begin
            len_m1_d = cmd_len - ADDR_W'(1);
            addr_d   = '0;
            i_d      = 8'd0;
            j_d      = 8'd0;
            addra_d  = '0;
            bram_i_d = 8'd0;
            bram_j_d = 8'd0;
        end
        if (in_hs) begin
            // Coordinates travel with the write so the tile sees the BRAM the word belongs to.
            wea_d    = 1'b1;
            addra_d  = addr_q;
            dia_d    = in_data;
            bram_i_d = i_q;
            bram_j_d = j_q;
            addr_d   = addr_nx;
            i_d      = i_nx;
            j_d      = j_nx;
        end
        if (out_hs) begin
            // Address moves only on the output handshake, so a stalled word keeps ADDRA steady.
            addr_d   = addr_nx;
            i_d      = i_nx;
            j_d      = j_nx;
            addra_d  = addr_nx;
            bram_i_d = i_nx;
            bram_j_d = j_nx;
        end
        if (state_q == S_RD_WAIT) begin
            out_data_d = DOA;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_m1_q   <= '0;
            addr_q     <= '0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dia_q      <= 16'h0;
            bram_i_q   <= 8'd0;
            bram_j_q   <= 8'd0;
            out_data_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            len_m1_q   <= len_m1_d;
            addr_q     <= addr_d;
            i_q        <= i_d;
            j_q        <= j_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dia_q      <= dia_d;
            bram_i_q   <= bram_i_d;
            bram_j_q   <= bram_j_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef TILE_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Running sum of every word that crosses either stream during a command; held after done.
    always_comb begin
        csum_d = csum_q;
        if (cmd_hs) begin
            csum_d = 16'h0;
        end else if (in_hs) begin
            csum_d = csum_q + in_data;
        end else if (out_hs) begin
            csum_d = csum_q + out_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= 16'h0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'h0;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_WR);
    assign out_valid = (state_q == S_RD_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign external  = busy && !done;
    assign start_out = start_in & ~busy;
    assign BRAM_i    = bram_i_q;
    assign BRAM_j    = bram_j_q;
    assign WEA       = wea_q;
    assign ADDRA     = addra_q;
    assign DIA       = dia_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_tile_bram_loader.sv
// Bench for tile_bram_loader: a tile memory model on port A, a command table, hand-written reset/stall cases and random traffic.
// Expected data, write coordinates and sums come from sweep arithmetic over the command length.
// Inputs are driven and outputs sampled on the falling edge.
module tb_tile_bram_loader;

    localparam int TD   = 2;
    localparam int AW   = 10;
    localparam int MEMW = TD * TD * 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_len;
    logic          in_valid, in_ready;
    logic [15:0]   in_data;
    logic          out_valid, out_ready;
    logic [15:0]   out_data;
    logic          start_in, start_out;
    logic          busy, done, external;
    logic [7:0]    BRAM_i, BRAM_j;
    logic          WEA;
    logic [AW-1:0] ADDRA;
    logic [15:0]   DIA;
    logic [15:0]   DOA;
    logic [15:0]   checksum;

    int errors = 0;
    int checks = 0;

    logic [15:0] tmem    [MEMW];   // the tile's BRAMs as the DUT sees them
    logic [15:0] exp_mem [MEMW];   // what the BRAMs should hold

    tile_bram_loader #(.TILE_DIM(TD), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .start_in(start_in), .start_out(start_out),
        .busy(busy), .done(done), .external(external),
        .BRAM_i(BRAM_i), .BRAM_j(BRAM_j),
        .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(DOA),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Tile port A: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        int idx;
        idx = (int'(BRAM_i) * TD + int'(BRAM_j)) * 1024 + int'(ADDRA);
        if (idx < MEMW) begin
            if (WEA) tmem[idx] <= DIA;
            DOA <= tmem[idx];
        end else begin
            DOA <= 16'h0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Flat BRAM location of the k-th word of a sweep with the given words-per-BRAM.
    function automatic int loc(input int k, input int len);
        int blk, bi, bj;
        blk = k / len;
        bj  = blk % TD;
        bi  = blk / TD;
        return (bi * TD + bj) * 1024 + (k % len);
    endfunction

    typedef struct {
        bit wr;
        int len;        // cmd_len field value, 0 means 1024
        int exp_busy;   // busy cycles incl. DONE, 0 = not checked
        int stall_word; // dump word index held back, -1 = none
        int stall_cyc;
        bit ramp;       // load data k+1 instead of random
    } vec_t;

    task automatic run_cmd(input bit wr, input int len_f, input int exp_busy, input int stall_word,
                           input int stall_cyc, input bit ramp, input bit gaps, input bit blk_start);
        int len, n, k, wn, busy_cnt, cyc, limit, stall_ctr, stall_bad, held_a;
        bit got_done, st_checked;
        logic [15:0] held_d, exp_sum;
        logic [15:0] words[$];
        len = (len_f == 0) ? 1024 : len_f;
        n   = TD * TD * len;
        exp_sum = 16'h0;
        for (int q = 0; q < n; q++) begin
            if (wr) begin
                words.push_back(ramp ? 16'(q + 1) : 16'($urandom));
                exp_mem[loc(q, len)] = words[q];
            end
            exp_sum = exp_sum + exp_mem[loc(q, len)];
        end
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_len   = AW'(len_f);
        start_in  = blk_start;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0; wn = 0; busy_cnt = 0; cyc = 0; stall_ctr = 0; stall_bad = 0;
        held_d = 16'h0; held_a = 0; got_done = 0; st_checked = 0;
        limit = n * 12 + stall_cyc + 50;
        while (!got_done && cyc < limit) begin
            cyc++;
            if (busy) busy_cnt++;
            if (start_in && busy && !st_checked) begin
                check("start_blocked", {31'd0, start_out}, 32'd0);
                st_checked = 1;
            end
            if (WEA) begin
                check("write_loc", (int'(BRAM_i) * TD + int'(BRAM_j)) * 1024 + int'(ADDRA), loc(wn, len));
                wn++;
            end
            if (done) got_done = 1;
            if (wr) begin
                if (in_ready && k < n && (!gaps || $urandom_range(0, 2) != 0)) begin
                    in_valid = 1'b1;
                    in_data  = words[k];
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end else if (out_valid) begin
                if (k == stall_word && stall_ctr < stall_cyc) begin
                    if (stall_ctr == 0) begin
                        held_d = out_data;
                        held_a = int'(ADDRA);
                    end else if (out_data !== held_d || int'(ADDRA) != held_a) begin
                        stall_bad++;
                    end
                    stall_ctr++;
                    out_ready = 1'b0;
                end else if (gaps && $urandom_range(0, 2) == 0) begin
                    out_ready = 1'b0;
                end else begin
                    if (k == stall_word && int'(ADDRA) != held_a) stall_bad++;
                    out_ready = 1'b1;
                    check("dump_word", {16'd0, out_data}, {16'd0, exp_mem[loc(k, len)]});
                    k++;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        start_in  = 1'b0;
        check("done_seen", {31'd0, got_done}, 32'd1);
        check("handshakes", k, n);
        if (wr) check("write_count", wn, n);
        if (exp_busy != 0) check("busy_cycles", busy_cnt, exp_busy);
        if (stall_cyc > 0) check("stall_stable", stall_bad, 0);
        check("done_once", {30'd0, done, busy}, 32'd0);
        check("ready_after", {31'd0, cmd_ready}, 32'd1);
`ifdef TILE_LOADER_CHECKSUM_EN
        check("checksum", {16'd0, checksum}, {16'd0, exp_sum});
`else
        check("checksum", {16'd0, checksum}, 32'd0);
`endif
        if (wr) begin
            int bad;
            bad = 0;
            for (int q = 0; q < n; q++) begin
                if (tmem[loc(q, len)] !== exp_mem[loc(q, len)]) bad++;
            end
            check("mem_contents", bad, 0);
        end
    endtask

    initial begin
        vec_t tbl[9];
        int k, cyc;
        tbl[0] = '{1, 4, 17, -1, 0, 1};
        tbl[1] = '{0, 4, 49, -1, 0, 0};
        tbl[2] = '{0, 4, 54,  1, 5, 0};
        tbl[3] = '{1, 1, 5,  -1, 0, 0};
        tbl[4] = '{0, 1, 13, -1, 0, 0};
        tbl[5] = '{1, 3, 13, -1, 0, 0};
        tbl[6] = '{0, 3, 37, -1, 0, 0};
        tbl[7] = '{1, 0, 4097, -1, 0, 0};
        tbl[8] = '{0, 0, 12289, -1, 0, 0};

        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = '0;
        in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0; start_in = 1'b0;

        // Outputs while reset is held.
        #12;
        check("rst_wea",      {31'd0, WEA},       32'd0);
        check("rst_external", {31'd0, external},  32'd0);
        check("rst_busy",     {31'd0, busy},      32'd0);
        check("rst_done",     {31'd0, done},      32'd0);
        check("rst_out_valid",{31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready},  32'd0);
        check("rst_addra",    {22'd0, ADDRA},     32'd0);
        check("rst_dia",      {16'd0, DIA},       32'd0);
        check("rst_bram_ij",  {16'd0, BRAM_i, BRAM_j}, 32'd0);
        check("rst_out_data", {16'd0, out_data},  32'd0);
        check("rst_checksum", {16'd0, checksum},  32'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("cmd_ready_rel", {31'd0, cmd_ready}, 32'd1);
        start_in = 1'b1;
        #1;
        check("start_idle", {31'd0, start_out}, 32'd1);
        start_in = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_cmd(tbl[v].wr, tbl[v].len, tbl[v].exp_busy, tbl[v].stall_word,
                    tbl[v].stall_cyc, tbl[v].ramp, 1'b0, (v == 1));
            if (v == 0) check("bram11_a3", {16'd0, tmem[3 * 1024 + 3]}, 32'h0010);
        end

        // Reset in the middle of a load after 7 accepted words.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = AW'(4);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < 7 && cyc < 50) begin
            cyc++;
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = 16'(k + 16'h100);
                k++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("partial_words", k, 7);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_external", {31'd0, external}, 32'd0);
        check("mid_rst_wea",      {31'd0, WEA},      32'd0);
        check("mid_rst_busy",     {31'd0, busy},     32'd0);
        @(negedge clk);
        check("mid_rst_cmd_ready",{31'd0, cmd_ready}, 32'd1);
        check("mid_rst_ext_next", {31'd0, external},  32'd0);
        reset = 1'b1;
        run_cmd(1'b1, 4, 17, -1, 0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 4, 49, -1, 0, 1'b0, 1'b0, 1'b0);

        // Random lengths with random gaps on both streams.
        for (int r = 0; r < 5; r++) begin
            int rl;
            rl = $urandom_range(1, 6);
            run_cmd(1'b1, rl, 0, -1, 0, 1'b0, 1'b1, 1'b0);
            run_cmd(1'b0, rl, 0, -1, 0, 1'b0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
